// File: rtl/npc_module_if.sv
// Next-PC bus bundle: groups the per-instruction inputs and PC outputs of npc_module.
// Latency: none; pure wiring.
// Backpressure: none; pc_en is the only stall, and the master drives it.
// Signals:
//   master drives Zero, Npc_op, Pc, instruction, Radata, bsoal_data, pc_en.
//   master reads PcAddr4, Npc, pc_q.
interface npc_module_if;
  logic        Zero;         // ALU equality flag
  logic [2:0]  Npc_op;       // next-PC select code
  logic [31:0] Pc;           // PC of the executing instruction
  logic [31:0] instruction;  // executing instruction word
  logic [31:0] Radata;       // GPR[rs], the jr target
  logic [31:0] bsoal_data;   // bsoal condition word, bit 0 only
  logic        pc_en;        // PC register update enable (0 = stall)
  logic [31:0] PcAddr4;      // Pc + 4, the link value
  logic [31:0] Npc;          // combinational next PC
  logic [31:0] pc_q;         // registered PC (fetch address)

  modport master (
    output Zero, Npc_op, Pc, instruction, Radata, bsoal_data, pc_en,
    input  PcAddr4, Npc, pc_q
  );

  modport slave (
    input  Zero, Npc_op, Pc, instruction, Radata, bsoal_data, pc_en,
    output PcAddr4, Npc, pc_q
  );
endinterface

// File: rtl/npc_module.sv
// Next-PC selection and the PC register: decodes branch, jump and jr targets into Npc.
// Latency: Npc and PcAddr4 are combinational; pc_q loads Npc on the rising edge when pc_en is high.
// Backpressure: pc_en = 0 stalls by holding pc_q. rst_n is async active-low and forces RESET_PC.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : npc_module_if.slave, carrying the decode inputs and the PcAddr4/Npc/pc_q outputs
module npc_module #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         rst_n,
  npc_module_if.slave  bus
);

  localparam logic [2:0] OP_SEQ   = 3'd0;
  localparam logic [2:0] OP_BEQ   = 3'd1;
  localparam logic [2:0] OP_J     = 3'd2;
  localparam logic [2:0] OP_JR    = 3'd3;
  localparam logic [2:0] OP_BSOAL = 3'd4;
  localparam logic [2:0] OP_BNE   = 3'd5;

  logic [31:0] pc_add4;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] npc;
  logic [31:0] pc_d;
  logic [31:0] pc_q_q;

  // Target arithmetic. Every sum wraps modulo 2^32 and no overflow flag is produced.
  always_comb begin
    pc_add4 = bus.Pc + 32'd4;
    // The word offset is sign-extended from the 16-bit immediate and scaled by 4.
    br_off  = {{14{bus.instruction[15]}}, bus.instruction[15:0], 2'b00};
    br_tgt  = pc_add4 + br_off;
    // The jump keeps the current 256 MB region. It uses Pc, not Pc+4.
    j_tgt   = {bus.Pc[31:28], bus.instruction[25:0], 2'b00};
  end

  // Next-PC select. Codes 6 and 7 are reserved and fall through to sequential.
  always_comb begin
    npc = pc_add4;
    case (bus.Npc_op)
      OP_SEQ:   npc = pc_add4;
      OP_BEQ:   npc = bus.Zero ? br_tgt : pc_add4;
      OP_J:     npc = j_tgt;
      OP_JR:    npc = bus.Radata;  // taken as given, with no alignment masking
      // Only bit 0 is examined, so X/Z on the upper bits cannot leak into Npc.
      OP_BSOAL: npc = (bus.bsoal_data[0] == 1'b1) ? br_tgt : pc_add4;
      OP_BNE:   npc = bus.Zero ? pc_add4 : br_tgt;
      default:  npc = pc_add4;
    endcase
  end

  always_comb begin
    pc_d = bus.pc_en ? npc : pc_q_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q_q <= RESET_PC;
    end else begin
      pc_q_q <= pc_d;
    end
  end

  assign bus.PcAddr4 = pc_add4;
  assign bus.Npc     = npc;
  assign bus.pc_q    = pc_q_q;

endmodule

// File: tb/tb_npc_module.sv
// Directed and randomised bench for npc_module. Expected values are queued when stimulus is applied and popped at check time.
// Latency: combinational results are checked 1 time unit after drive; pc_q is checked 1 time unit after each rising edge.
// Backpressure: exercises the pc_en stall, and reset asserted between edges.
module tb_npc_module;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_npc_q[$];
  logic [31:0] exp_a4_q[$];
  logic [31:0] exp_pc_q[$];

  npc_module_if bus ();

  npc_module #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference next-PC, written from the instruction-set definitions.
  function automatic logic [31:0] ref_npc(input logic [2:0] op, input logic [31:0] pc,
                                          input logic [31:0] ins, input logic [31:0] rad,
                                          input logic [31:0] bso, input logic z);
    logic [31:0] seq, bt, jt;
    seq = pc + 32'd4;
    bt  = seq + ({{16{ins[15]}}, ins[15:0]} << 2);
    jt  = {pc[31:28], ins[25:0], 2'b00};
    case (op)
      3'd1:    return z ? bt : seq;
      3'd2:    return jt;
      3'd3:    return rad;
      3'd4:    return bso[0] ? bt : seq;
      3'd5:    return z ? seq : bt;
      default: return seq;
    endcase
  endfunction

  task automatic comb_step(input string tag, input logic [2:0] op, input logic [31:0] pc,
                           input logic [31:0] ins, input logic [31:0] rad,
                           input logic [31:0] bso, input logic z,
                           input logic [31:0] e_npc, input logic [31:0] e_a4);
    bus.Npc_op      = op;
    bus.Pc          = pc;
    bus.instruction = ins;
    bus.Radata      = rad;
    bus.bsoal_data  = bso;
    bus.Zero        = z;
    exp_npc_q.push_back(e_npc);
    exp_a4_q.push_back(e_a4);
    #1;
    check({tag, "_npc"}, bus.Npc, exp_npc_q.pop_front());
    check({tag, "_a4"}, bus.PcAddr4, exp_a4_q.pop_front());
  endtask

  task automatic edge_check(input string tag);
    @(posedge clk);
    #1;
    check(tag, bus.pc_q, exp_pc_q.pop_front());
  endtask

  initial begin
    logic [31:0] xb1, xb0;
    logic [2:0]  r_op;
    logic [31:0] r_pc, r_ins, r_rad, r_bso;
    logic        r_z;
    xb1 = 32'hxxxx_xxx1;
    xb0 = 32'hzzzz_xxx0;

    rst_n           = 1'b1;
    bus.pc_en       = 1'b1;
    bus.Npc_op      = 3'd0;
    bus.Pc          = 32'h0;
    bus.instruction = 32'h0;
    bus.Radata      = 32'h0;
    bus.bsoal_data  = 32'h0;
    bus.Zero        = 1'b0;

    // Assert reset between edges; pc_q must respond without a clock edge.
    #3 rst_n = 1'b0;
    #1 check("rst_async", bus.pc_q, 32'h0000_3000);

    // Combinational decode while reset is held.
    comb_step("bsoal_t",  3'd4, 32'h3000, 32'hFFFF_AAAA, 0, 32'd1, 0, 32'hFFFE_DAAC, 32'h3004);
    comb_step("bsoal_nt", 3'd4, 32'h3000, 32'hFFFF_AAAA, 0, 32'd0, 0, 32'h0000_3004, 32'h3004);
    comb_step("bsoal_x1", 3'd4, 32'h3000, 32'hFFFF_AAAA, 0, xb1,   0, 32'hFFFE_DAAC, 32'h3004);
    comb_step("bsoal_x0", 3'd4, 32'h3000, 32'hFFFF_AAAA, 0, xb0,   0, 32'h0000_3004, 32'h3004);
    comb_step("beq_z1",   3'd1, 32'h3000, 32'h0000_0003, 0, 0, 1, 32'h3010, 32'h3004);
    comb_step("beq_z0",   3'd1, 32'h3000, 32'h0000_0003, 0, 0, 0, 32'h3004, 32'h3004);
    comb_step("bne_z1",   3'd5, 32'h3000, 32'h0000_0003, 0, 0, 1, 32'h3004, 32'h3004);
    comb_step("bne_z0",   3'd5, 32'h3000, 32'h0000_0003, 0, 0, 0, 32'h3010, 32'h3004);
    comb_step("jump",     3'd2, 32'h3000_3000, 32'h0C00_0C01, 0, 0, 0, 32'h3000_3004, 32'h3000_3004);
    comb_step("jr",       3'd3, 32'h3000, 0, 32'h0000_4ABC, 0, 0, 32'h0000_4ABC, 32'h3004);
    comb_step("jr_unal",  3'd3, 32'h3000, 0, 32'h0000_4ABF, 0, 0, 32'h0000_4ABF, 32'h3004);
    comb_step("rsv6",     3'd6, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1, 1, 1, 32'h1234_567C, 32'h1234_567C);
    comb_step("rsv7",     3'd7, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1, 1, 0, 32'h1234_567C, 32'h1234_567C);
    comb_step("wrap",     3'd0, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0, 32'h0);
    comb_step("br_back",  3'd1, 32'h0, 32'h0000_FFFF, 0, 0, 1, 32'h0, 32'h4);

    // Reset must win over pc_en and a pending non-sequential Npc.
    bus.pc_en = 1'b1;
    exp_pc_q.push_back(32'h0000_3000);
    edge_check("rst_hold");

    for (int i = 0; i < 24; i++) begin
      r_op  = 3'($urandom_range(0, 7));
      r_pc  = $urandom;
      r_ins = $urandom;
      r_rad = $urandom;
      r_bso = $urandom;
      r_z   = 1'($urandom_range(0, 1));
      comb_step($sformatf("rnd%0d", i), r_op, r_pc, r_ins, r_rad, r_bso, r_z,
                ref_npc(r_op, r_pc, r_ins, r_rad, r_bso, r_z), r_pc + 32'd4);
    end

    // Sequential run: release reset and feed pc_q back into Pc.
    @(negedge clk);
    bus.Npc_op = 3'd0;
    bus.Zero   = 1'b0;
    bus.Pc     = bus.pc_q;
    bus.pc_en  = 1'b1;
    rst_n      = 1'b1;
    exp_pc_q.push_back(32'h0000_3004);
    edge_check("seq_1");
    bus.Pc = bus.pc_q;
    exp_pc_q.push_back(32'h0000_3008);
    edge_check("seq_2");
    bus.Pc    = bus.pc_q;
    bus.pc_en = 1'b0;
    exp_pc_q.push_back(32'h0000_3008);
    edge_check("stall_1");
    exp_pc_q.push_back(32'h0000_3008);
    edge_check("stall_2");
    bus.pc_en  = 1'b1;
    bus.Npc_op = 3'd3;
    bus.Radata = 32'h0000_4ABC;
    exp_pc_q.push_back(32'h0000_4ABC);
    edge_check("load_jr");

    // Reset asserted mid-cycle takes effect at once and holds through an edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid", bus.pc_q, 32'h0000_3000);
    exp_pc_q.push_back(32'h0000_3000);
    edge_check("rst_override");
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc_q.push_back(32'h0000_4ABC);
    edge_check("first_load");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
